// File: rtl/rgb_pwm_ctrl_if.sv
// Register-bus bundle between the fabric and rgb_pwm_ctrl.
// One access per cycle in which cs is high; ready and read_data
// answer one cycle later.
interface rgb_pwm_ctrl_if;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output cs, we, address, write_data,
    input  read_data, ready
  );

  modport slave (
    input  cs, we, address, write_data,
    output read_data, ready
  );
endinterface

// File: rtl/rgb_pwm_ctrl.sv
// PWM generator feeding the iCE40 RGB LED driver primitive.
// Three 8-bit duty channels compared against a 255-tick period counter,
// tick rate set by a prescaler, optional ON/OFF blink pattern counted in
// whole periods. Active duties only change at period boundaries, so the
// registered pwm outputs never glitch mid-period.
module rgb_pwm_ctrl #(
  parameter int PRESCALE_W = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  rgb_pwm_ctrl_if.slave  bus,
  output logic           led_en,
  output logic           curr_en,
  output logic [2:0]     pwm
);

  localparam logic [7:0]  ADDR_NAME0    = 8'h00;
  localparam logic [7:0]  ADDR_VERSION  = 8'h01;
  localparam logic [7:0]  ADDR_CTRL     = 8'h08;
  localparam logic [7:0]  ADDR_DUTY     = 8'h09;
  localparam logic [7:0]  ADDR_PRESCALE = 8'h0a;
  localparam logic [7:0]  ADDR_BLINK    = 8'h0b;
  localparam logic [7:0]  ADDR_STATUS   = 8'h0c;
  localparam logic [31:0] NAME0_VAL     = 32'h72676270;
  localparam logic [31:0] VERSION_VAL   = 32'h00000001;

  typedef enum logic {ST_ON, ST_OFF} state_t;

  // software-visible registers
  logic [1:0]            ctrl_reg, ctrl_next;
  logic [23:0]           duty_reg;
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [15:0]           blink_reg;

  // PWM engine state
  logic [23:0]           duty_act_reg;
  logic [PRESCALE_W-1:0] pre_cnt_reg;
  logic [7:0]            pwm_cnt_reg;
  logic [7:0]            blink_cnt_reg, blink_cnt_next;
  state_t                state_reg, state_next;

  // registered outputs
  logic [31:0]           read_data_reg, rdata_mux;
  logic                  ready_reg;
  logic                  led_en_reg;
  logic [2:0]            pwm_reg, pwm_next;

  logic wr_en, wr_ctrl, wr_duty, wr_prescale, wr_blink;
  logic en_rise, run, tick, wrap;
  logic [8:0] on_lim, off_lim, cnt_inc;
  logic unused_bits;

  assign wr_en       = bus.cs & bus.we;
  assign wr_ctrl     = wr_en & (bus.address == ADDR_CTRL);
  assign wr_duty     = wr_en & (bus.address == ADDR_DUTY);
  assign wr_prescale = wr_en & (bus.address == ADDR_PRESCALE);
  assign wr_blink    = wr_en & (bus.address == ADDR_BLINK);
  assign unused_bits = ^bus.write_data[31:24];

  // CTRL as it will be after this edge; lets a disable write clear the
  // counters on the same edge and lets an enable write start a fresh period.
  assign ctrl_next = wr_ctrl ? bus.write_data[1:0] : ctrl_reg;
  assign en_rise   = ctrl_next[0] & ~ctrl_reg[0];
  assign run       = ctrl_next[0] & ctrl_reg[0];
  assign tick      = run & (pre_cnt_reg == prescale_reg);
  assign wrap      = tick & (pwm_cnt_reg == 8'd254);

  // A zero period count still means one period in that phase.
  assign on_lim  = (blink_reg[7:0]  == 8'd0) ? 9'd1 : {1'b0, blink_reg[7:0]};
  assign off_lim = (blink_reg[15:8] == 8'd0) ? 9'd1 : {1'b0, blink_reg[15:8]};
  assign cnt_inc = {1'b0, blink_cnt_reg} + 9'd1;

  // Register file writes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl_reg     <= '0;
      duty_reg     <= '0;
      prescale_reg <= '0;
      blink_reg    <= '0;
    end else begin
      ctrl_reg <= ctrl_next;
      if (wr_duty)     duty_reg     <= bus.write_data[23:0];
      if (wr_prescale) prescale_reg <= bus.write_data[PRESCALE_W-1:0];
      if (wr_blink)    blink_reg    <= bus.write_data[15:0];
    end
  end

  // Prescaler, period counter and active-duty latch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pre_cnt_reg  <= '0;
      pwm_cnt_reg  <= '0;
      duty_act_reg <= '0;
    end else if (!run) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
      if (en_rise) duty_act_reg <= duty_reg;
    end else begin
      if (wr_prescale || tick) pre_cnt_reg <= '0;
      else                     pre_cnt_reg <= pre_cnt_reg + 1'b1;
      if (tick) pwm_cnt_reg <= wrap ? 8'd0 : pwm_cnt_reg + 8'd1;
      // old shadow wins when a DUTY write lands on the wrap edge
      if (wrap) duty_act_reg <= duty_reg;
    end
  end

  // Blink FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_ON;
      blink_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      blink_cnt_reg <= blink_cnt_next;
    end
  end

  // Blink FSM next state: advances only on period wrap.
  always_comb begin
    state_next     = state_reg;
    blink_cnt_next = blink_cnt_reg;
    if (!run || !ctrl_reg[1]) begin
      state_next     = ST_ON;
      blink_cnt_next = '0;
    end else if (wrap) begin
      case (state_reg)
        ST_ON: begin
          if (cnt_inc >= on_lim) begin
            state_next     = ST_OFF;
            blink_cnt_next = '0;
          end else begin
            blink_cnt_next = cnt_inc[7:0];
          end
        end
        ST_OFF: begin
          if (cnt_inc >= off_lim) begin
            state_next     = ST_ON;
            blink_cnt_next = '0;
          end else begin
            blink_cnt_next = cnt_inc[7:0];
          end
        end
        default: begin
          state_next     = ST_ON;
          blink_cnt_next = '0;
        end
      endcase
    end
  end

  // Per-channel compare against the active duty.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign pwm_next[gi] = ctrl_reg[0] & (state_reg == ST_ON) &
                            (pwm_cnt_reg < duty_act_reg[gi*8 +: 8]);
    end
  endgenerate

  // Driver-facing outputs, registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led_en_reg <= 1'b0;
      pwm_reg    <= '0;
    end else begin
      led_en_reg <= ctrl_reg[0];
      pwm_reg    <= pwm_next;
    end
  end

  // Read mux; unmapped addresses read as zero.
  always_comb begin
    rdata_mux = '0;
    case (bus.address)
      ADDR_NAME0:    rdata_mux = NAME0_VAL;
      ADDR_VERSION:  rdata_mux = VERSION_VAL;
      ADDR_CTRL:     rdata_mux[1:0] = ctrl_reg;
      ADDR_DUTY:     rdata_mux[23:0] = duty_reg;
      ADDR_PRESCALE: rdata_mux[PRESCALE_W-1:0] = prescale_reg;
      ADDR_BLINK:    rdata_mux[15:0] = blink_reg;
      ADDR_STATUS: begin
        rdata_mux[7:0]   = pwm_cnt_reg;
        rdata_mux[8]     = (state_reg == ST_ON);
        rdata_mux[23:16] = blink_cnt_reg;
      end
      default:       rdata_mux = '0;
    endcase
  end

  // Bus response: ready and read data one cycle after each cs cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ready_reg     <= 1'b0;
      read_data_reg <= '0;
    end else begin
      ready_reg <= bus.cs;
      if (bus.cs) read_data_reg <= rdata_mux;
    end
  end

  assign bus.ready     = ready_reg;
  assign bus.read_data = read_data_reg;
  assign led_en        = led_en_reg;
  assign curr_en       = led_en_reg;
  assign pwm           = pwm_reg;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl. Expected pwm is derived from
// elapsed cycles since the enable edge: tick index, period index, duty in
// force for that period and blink phase by modular arithmetic.
module tb_rgb_pwm_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       led_en, curr_en;
  logic [2:0] pwm;

  rgb_pwm_ctrl_if bus();

  rgb_pwm_ctrl #(.PRESCALE_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .led_en  (led_en),
    .curr_en (curr_en),
    .pwm     (pwm)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [31:0] data);
    bus.cs = 1'b1; bus.we = 1'b1; bus.address = addr; bus.write_data = data;
    step();
    bus.cs = 1'b0; bus.we = 1'b0;
    check_val($sformatf("wr_ready@%02h", addr), {31'b0, bus.ready}, 32'd1);
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [31:0] data);
    bus.cs = 1'b1; bus.we = 1'b0; bus.address = addr;
    step();
    bus.cs = 1'b0;
    check_val($sformatf("rd_ready@%02h", addr), {31'b0, bus.ready}, 32'd1);
    data = bus.read_data;
  endtask

  task automatic read_check(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    bus_read(addr, d);
    check_val(tag, d, exp);
  endtask

  // Blink phase of period k (1 = ON) and periods elapsed in that phase.
  function automatic int phase_of(input int k, input bit blk, input int on, input int off);
    int onl, offl;
    if (!blk) return 1;
    onl  = (on  == 0) ? 1 : on;
    offl = (off == 0) ? 1 : off;
    return ((k % (onl + offl)) < onl) ? 1 : 0;
  endfunction

  function automatic int bcnt_of(input int k, input bit blk, input int on, input int off);
    int onl, offl, r;
    if (!blk) return 0;
    onl  = (on  == 0) ? 1 : on;
    offl = (off == 0) ? 1 : off;
    r = k % (onl + offl);
    return (r < onl) ? r : r - onl;
  endfunction

  // Reference: m cycles after the enable edge.
  function automatic logic [31:0] status_at(input int m, input int p, input bit blk,
                                            input int on, input int off);
    int L, k, c;
    L = 255 * (p + 1);
    k = m / L;
    c = (m / (p + 1)) % 255;
    return 32'(c) | (32'(phase_of(k, blk, on, off)) << 8) | (32'(bcnt_of(k, blk, on, off)) << 16);
  endfunction

  // Run nper periods right after the enable write edge. Optional DUTY write
  // issued at loop index n_w, optional STATUS read at n_r (-1 = none).
  task automatic run(input int nper, input int p, input logic [23:0] d_old,
                     input logic [23:0] d_new, input int n_w, input int n_r,
                     input bit blk, input int on, input int off, input string name);
    int L, k, c, ph, err, dch;
    int hi[3];
    bit wr_pend, rd_pend;
    logic [31:0] exp_st;
    logic [23:0] dk;
    logic [2:0]  e;
    L = 255 * (p + 1);
    err = 0; wr_pend = 0; rd_pend = 0; exp_st = '0;
    for (int i = 0; i < 3; i++) hi[i] = 0;
    for (int n = 0; n < nper * L; n++) begin
      step();
      if (wr_pend) begin
        check_val({name, " duty_wr_ready"}, {31'b0, bus.ready}, 32'd1);
        bus.cs = 1'b0; bus.we = 1'b0; wr_pend = 0;
      end
      if (rd_pend) begin
        check_val({name, " status_ready"}, {31'b0, bus.ready}, 32'd1);
        check_val({name, " status"}, bus.read_data, exp_st);
        bus.cs = 1'b0; rd_pend = 0;
      end
      k  = n / L;
      c  = (n / (p + 1)) % 255;
      ph = phase_of(k, blk, on, off);
      dk = (n_w >= 0 && (n_w + 2) < k * L) ? d_new : d_old;
      for (int i = 0; i < 3; i++) begin
        dch  = int'(dk[i*8 +: 8]);
        e[i] = (ph == 1) && (c < dch);
        if (pwm[i]) hi[i]++;
      end
      if (pwm !== e) err++;
      if (n == n_w) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.address = 8'h09; bus.write_data = {8'h00, d_new};
        wr_pend = 1;
      end
      if (n == n_r) begin
        bus.cs = 1'b1; bus.we = 1'b0; bus.address = 8'h0c;
        exp_st = status_at(n_r + 1, p, blk, on, off);
        rd_pend = 1;
      end
      if (n % L == L - 1) begin
        for (int i = 0; i < 3; i++) begin
          dch = (ph == 1) ? int'(dk[i*8 +: 8]) * (p + 1) : 0;
          check_val($sformatf("%s p%0d ch%0d high", name, k, i), hi[i], dch);
          hi[i] = 0;
        end
        check_val($sformatf("%s p%0d bad_cycles", name, k), err, 32'd0);
        err = 0;
      end
    end
    check_val({name, " led_en"}, {31'b0, led_en}, 32'd1);
    check_val({name, " curr_en"}, {31'b0, curr_en}, 32'd1);
  endtask

  task automatic setup(input int p, input logic [15:0] blink, input logic [23:0] duty,
                       input logic [1:0] ctrl);
    bus_write(8'h08, 32'd0);
    bus_write(8'h0a, 32'(p));
    bus_write(8'h0b, {16'h0, blink});
    bus_write(8'h09, {8'h00, duty});
    bus_write(8'h08, {30'b0, ctrl});
  endtask

  initial begin
    int p, on, off, nper, n_w, n_r, L;
    bit blk;
    logic [23:0] d0, d1;
    logic [31:0] rd;

    bus.cs = 1'b0; bus.we = 1'b0; bus.address = '0; bus.write_data = '0;
    reset_n = 1'b0;

    // Reset held 4 cycles while cs toggles.
    for (int i = 0; i < 4; i++) begin
      bus.cs = i[0];
      step();
      check_val($sformatf("rst%0d pwm", i), {29'b0, pwm}, 32'd0);
      check_val($sformatf("rst%0d led_en", i), {31'b0, led_en}, 32'd0);
      check_val($sformatf("rst%0d ready", i), {31'b0, bus.ready}, 32'd0);
      check_val($sformatf("rst%0d read_data", i), bus.read_data, 32'd0);
    end
    bus.cs = 1'b0;
    reset_n = 1'b1;
    step();

    read_check(8'h00, 32'h72676270, "name0");
    read_check(8'h01, 32'h00000001, "version");
    read_check(8'h05, 32'h0, "unmapped");
    read_check(8'h08, 32'h0, "ctrl_rst");
    read_check(8'h0c, 32'h100, "status_rst");
    bus_write(8'h00, 32'hdeadbeef);
    read_check(8'h00, 32'h72676270, "name0_ro");

    // Duty sweep at full tick rate.
    setup(0, 16'h0, 24'hFF4000, 2'b01);
    run(2, 0, 24'hFF4000, 24'hFF4000, -1, 100, 0, 0, 0, "sweep");

    // Prescaler 3, ch0 duty 10.
    d0 = {$urandom_range(0, 255), $urandom_range(0, 255), 8'd10};
    setup(3, 16'h0, d0, 2'b01);
    run(1, 3, d0, d0, -1, 517, 0, 0, 0, "presc");

    // Mid-period duty update applies from the next period.
    setup(0, 16'h0, 24'h000064, 2'b01);
    run(2, 0, 24'h000064, 24'h0000C8, 49, -1, 0, 0, 0, "glitch");

    // DUTY write landing on the wrap edge: old value still used next period.
    setup(0, 16'h0, 24'h102030, 2'b01);
    run(3, 0, 24'h102030, 24'h805020, 253, 10, 0, 0, 0, "wrapwr");

    // Blink 2 on / 3 off.
    setup(0, 16'h0302, 24'hFFFFFF, 2'b11);
    run(10, 0, 24'hFFFFFF, 24'hFFFFFF, -1, 255 * 3 + $urandom_range(0, 200), 1, 2, 3, "blink");

    // Randomized configurations.
    p = 0; blk = 0; on = 0; off = 0; d1 = '0;
    for (int t = 0; t < 3; t++) begin
      p    = $urandom_range(0, 2);
      on   = $urandom_range(0, 2);
      off  = $urandom_range(0, 2);
      blk  = 1'($urandom_range(0, 1));
      d0   = 24'($urandom);
      d1   = 24'($urandom);
      nper = 3;
      L    = 255 * (p + 1);
      n_w  = $urandom_range(0, nper * L - 3);
      n_r  = (n_w + 3 + $urandom_range(0, 100)) % (nper * L - 2);
      setup(p, {8'(off), 8'(on)}, d0, {blk, 1'b1});
      run(nper, p, d0, d1, n_w, n_r, blk, on, off, $sformatf("rnd%0d", t));
    end
    read_check(8'h09, {8'h0, d1}, "duty_rb");
    read_check(8'h0a, 32'(p), "presc_rb");
    read_check(8'h0b, {16'h0, 8'(off), 8'(on)}, "blink_rb");

    // Disable mid-period, then re-enable without blink.
    for (int i = 0; i < int'($urandom_range(5, 30)); i++) step();
    bus_write(8'h08, 32'd0);
    step();
    check_val("dis pwm", {29'b0, pwm}, 32'd0);
    check_val("dis led_en", {31'b0, led_en}, 32'd0);
    check_val("dis curr_en", {31'b0, curr_en}, 32'd0);
    read_check(8'h0c, 32'h100, "dis status");
    bus_write(8'h08, 32'd1);
    run(1, p, d1, d1, -1, 30, 0, 0, 0, "reen");

    // Reset in the middle of a period.
    for (int i = 0; i < 40; i++) step();
    reset_n = 1'b0;
    step();
    check_val("midrst pwm", {29'b0, pwm}, 32'd0);
    check_val("midrst led_en", {31'b0, led_en}, 32'd0);
    check_val("midrst ready", {31'b0, bus.ready}, 32'd0);
    reset_n = 1'b1;
    step();
    read_check(8'h08, 32'h0, "midrst ctrl");
    read_check(8'h09, 32'h0, "midrst duty");
    read_check(8'h0c, 32'h100, "midrst status");
    rd = '0;
    bus_read(8'h01, rd);
    check_val("midrst version", rd, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
